// File: rtl/mmio_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer_pkg
// Description : Shared constants for the memory-mapped timer peripheral:
//               default window base, register byte offsets, CTRL/STATUS bit
//               positions and an offset helper used by the address decode.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_timer_pkg;

    // Default byte base of the 64-byte register window (low 6 bits zero).
    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'hFFFF_FF00;

    // Register byte offsets inside the window.
    localparam logic [5:0] OFF_CTRL    = 6'h00;
    localparam logic [5:0] OFF_COUNT   = 6'h04;
    localparam logic [5:0] OFF_COMPARE = 6'h08;
    localparam logic [5:0] OFF_STATUS  = 6'h0C;
    localparam logic [5:0] OFF_CYCLES  = 6'h10;
    localparam logic [5:0] OFF_RETIRED = 6'h14;

    // CTRL bit indices and width of the implemented CTRL field.
    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQEN      = 2;
    localparam int CTRL_W          = 3;

    // STATUS bit index.
    localparam int STATUS_MATCH = 0;

    // Word-aligned byte offset from address bits [5:2]; the byte lane bits
    // are ignored, so every access is treated as a full-word access.
    function automatic logic [5:0] reg_offset(input logic [3:0] word_sel);
        return {word_sel, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer_if
// Description : Data-port bundle between the pipeline M/W stages, the data
//               memory and the timer peripheral.
//               master : pipeline/memory side (drives strobe, address, store
//                        data, W-stage instruction and memory read data)
//               slave  : timer side (drives memory write enable and the read
//                        data returned to the pipeline)
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_timer_if;
    logic        MemWriteM;   // M-stage store strobe
    logic [31:0] DataAdrM;    // M-stage byte address
    logic [31:0] WriteDataM;  // M-stage store data
    logic [31:0] InstrW;      // W-stage instruction, zero means bubble
    logic [31:0] DmemRd;      // data memory read data (combinational)
    logic        DmemWe;      // data memory write enable
    logic [31:0] ReadDataM;   // read data back to the pipeline

    modport master (
        output MemWriteM, DataAdrM, WriteDataM, InstrW, DmemRd,
        input  DmemWe, ReadDataM
    );

    modport slave (
        input  MemWriteM, DataAdrM, WriteDataM, InstrW, DmemRd,
        output DmemWe, ReadDataM
    );
endinterface
`default_nettype wire

// File: rtl/mmio_timer_perf_counter.sv
`default_nettype none
// ============================================================================
// Module      : perf_counter
// Description : 32-bit free-running wrapping counter with increment enable.
// Ports       : clk    - system clock
//               reset  - synchronous active-high reset, clears the count
//               inc_en - add one on this rising edge
//               count  - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module perf_counter (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        inc_en,
    output logic [31:0]      count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_en) begin
            count_d = count_q + 32'd1;  // natural wrap at 2^32
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer
// Description : Memory-mapped timer and performance counters on the data
//               port. Claims a 64-byte window at BASE_ADDR; accesses outside
//               the window pass straight through to data memory.
// Ports       : clk   - system clock
//               reset - synchronous active-high reset
//               bus   - data-port bundle (slave side)
//               Irq   - registered interrupt request (MATCH & IRQEN)
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
    input  wire logic      clk,
    input  wire logic      reset,
    mmio_timer_if.slave    bus,
    output logic           Irq
);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic        w_hit;
    logic [5:0]  w_off;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_unused_adr_lo;

    assign w_hit        = (bus.DataAdrM[31:6] == BASE_ADDR[31:6]);
    assign w_off        = reg_offset(bus.DataAdrM[5:2]);
    assign w_wr         = bus.MemWriteM & w_hit;
    assign w_wr_ctrl    = w_wr & (w_off == OFF_CTRL);
    assign w_wr_count   = w_wr & (w_off == OFF_COUNT);
    assign w_wr_compare = w_wr & (w_off == OFF_COMPARE);
    assign w_wr_status  = w_wr & (w_off == OFF_STATUS);

    // Byte-lane bits carry no meaning for word registers.
    assign w_unused_adr_lo = ^bus.DataAdrM[1:0];

    // In-window stores never reach data memory.
    assign bus.DmemWe = bus.MemWriteM & ~w_hit;

    // ------------------------------------------------------------------
    // Free-running counters
    // ------------------------------------------------------------------
    logic [31:0] w_cycles;
    logic [31:0] w_retired;

    perf_counter u_cycles (
        .clk    (clk),
        .reset  (reset),
        .inc_en (1'b1),
        .count  (w_cycles)
    );

    perf_counter u_retired (
        .clk    (clk),
        .reset  (reset),
        .inc_en (bus.InstrW != 32'd0),
        .count  (w_retired)
    );

    // ------------------------------------------------------------------
    // Timer state
    // ------------------------------------------------------------------
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [31:0]       count_q,   count_d;
    logic [31:0]       compare_q, compare_d;
    logic              match_q,   match_d;
    logic              irq_q,     irq_d;
    logic              w_match_set;

    always_comb begin
        ctrl_d      = ctrl_q;
        count_d     = count_q;
        compare_d   = compare_q;
        match_d     = match_q;
        w_match_set = 1'b0;

        if (w_wr_ctrl) begin
            ctrl_d = bus.WriteDataM[CTRL_W-1:0];
        end

        // Compare always sees the pre-write COMPARE value this cycle.
        if (w_wr_compare) begin
            compare_d = bus.WriteDataM;
        end

        if (ctrl_q[CTRL_EN]) begin
            if (count_q == compare_q) begin
                w_match_set = 1'b1;
                count_d     = ctrl_q[CTRL_AUTORELOAD] ? 32'd0 : count_q + 32'd1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        // A software COUNT write overrides the increment/reload and
        // suppresses the match against the value being replaced.
        if (w_wr_count) begin
            count_d     = bus.WriteDataM;
            w_match_set = 1'b0;
        end

        // W1C first, then set: a fresh match beats a concurrent clear.
        if (w_wr_status && bus.WriteDataM[STATUS_MATCH]) begin
            match_d = 1'b0;
        end
        if (w_match_set) begin
            match_d = 1'b1;
        end

        irq_d = match_q & ctrl_q[CTRL_IRQEN];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= '0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            match_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            irq_q     <= irq_d;
        end
    end

    assign Irq = irq_q;

    // ------------------------------------------------------------------
    // Read mux (zero latency, like data memory)
    // ------------------------------------------------------------------
    logic [31:0] w_reg_rdata;

    always_comb begin
        w_reg_rdata = 32'd0;
        case (w_off)
            OFF_CTRL:    w_reg_rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
            OFF_COUNT:   w_reg_rdata = count_q;
            OFF_COMPARE: w_reg_rdata = compare_q;
            OFF_STATUS:  w_reg_rdata = {31'd0, match_q};
            OFF_CYCLES:  w_reg_rdata = w_cycles;
            OFF_RETIRED: w_reg_rdata = w_retired;
            default:     w_reg_rdata = 32'd0;
        endcase
    end

    assign bus.ReadDataM = w_hit ? w_reg_rdata : bus.DmemRd;

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_timer
// Description : Directed self-checking bench for mmio_timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_timer;
    import mmio_timer_pkg::*;

    localparam logic [31:0] C_BASE = 32'hFFFF_FF00;

    logic clk = 1'b0;
    logic reset;
    logic irq;

    mmio_timer_if bus();

    mmio_timer #(.BASE_ADDR(C_BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .Irq   (irq)
    );

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [5:0] off, input logic [31:0] exp, input string tag);
        bus.MemWriteM = 1'b0;
        bus.DataAdrM  = C_BASE | {26'd0, off};
        bus.DmemRd    = 32'h5A5A_5A5A;
        #1;
        chk(tag, bus.ReadDataM, exp);
    endtask

    task automatic wr(input logic [5:0] off, input logic [31:0] data);
        bus.MemWriteM  = 1'b1;
        bus.DataAdrM   = C_BASE | {26'd0, off};
        bus.WriteDataM = data;
        #1;
        chk("dmemwe_in_window", {31'd0, bus.DmemWe}, 32'd0);
        tick();
        bus.MemWriteM = 1'b0;
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        chk(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    logic [9:0] instr_pat;

    initial begin
        reset          = 1'b1;
        bus.MemWriteM  = 1'b0;
        bus.DataAdrM   = 32'd0;
        bus.WriteDataM = 32'd0;
        bus.InstrW     = 32'd0;
        bus.DmemRd     = 32'd0;
        tick();
        tick();

        // Reset state
        chk_irq(1'b0, "reset_irq");
        rd(OFF_CTRL,  32'd0, "reset_ctrl");
        rd(OFF_COUNT, 32'd0, "reset_count");

        reset = 1'b0;
        rd(OFF_CYCLES, 32'd0, "cycles_first_cycle");
        tick();
        rd(OFF_CYCLES, 32'd1, "cycles_second_cycle");

        // Pass-through outside the window
        bus.MemWriteM  = 1'b1;
        bus.DataAdrM   = 32'h0000_0040;
        bus.WriteDataM = 32'h0000_1234;
        #1;
        chk("pt_store_we", {31'd0, bus.DmemWe}, 32'd1);
        bus.MemWriteM = 1'b0;
        bus.DmemRd    = 32'h0000_CAFE;
        #1;
        chk("pt_load_data", bus.ReadDataM, 32'h0000_CAFE);
        chk("pt_load_we", {31'd0, bus.DmemWe}, 32'd0);
        tick();

        // Window write / readback, unmapped read, CTRL reserved bits
        wr(OFF_COMPARE, 32'd5);
        rd(OFF_COMPARE, 32'd5, "compare_readback");
        rd(6'h20, 32'd0, "unmapped_read");
        wr(OFF_CTRL, 32'hFFFF_FFF0);
        rd(OFF_CTRL, 32'd0, "ctrl_reserved_bits");

        // Auto-reload timer with IRQ
        wr(OFF_COMPARE, 32'd3);
        wr(OFF_COUNT, 32'd0);
        wr(OFF_CTRL, 32'd7);
        rd(OFF_CTRL, 32'd7, "ctrl_readback");
        rd(OFF_COUNT, 32'd0, "seq_0");
        tick(); rd(OFF_COUNT, 32'd1, "seq_1");
        tick(); rd(OFF_COUNT, 32'd2, "seq_2");
        tick(); rd(OFF_COUNT, 32'd3, "seq_3");
        rd(OFF_STATUS, 32'd0, "match_before_edge");
        tick();
        rd(OFF_COUNT, 32'd0, "seq_reload");
        rd(OFF_STATUS, 32'd1, "match_set");
        chk_irq(1'b0, "irq_lags_match");
        tick();
        rd(OFF_COUNT, 32'd1, "seq_after_reload");
        chk_irq(1'b1, "irq_rise");
        wr(OFF_STATUS, 32'd1);               // count 1 -> 2, MATCH cleared
        rd(OFF_STATUS, 32'd0, "w1c_clear");
        chk_irq(1'b1, "irq_hold_after_w1c");
        tick();
        chk_irq(1'b0, "irq_fall");
        rd(OFF_COUNT, 32'd3, "count_at_3");

        // Set wins over W1C on the match edge
        wr(OFF_STATUS, 32'd1);               // count == compare this cycle
        rd(OFF_STATUS, 32'd1, "set_wins");
        rd(OFF_COUNT, 32'd0, "reload_on_set_wins");
        tick();                              // count 1
        wr(OFF_STATUS, 32'd1);               // count 2, MATCH cleared
        rd(OFF_STATUS, 32'd0, "w1c_again");
        tick();
        rd(OFF_COUNT, 32'd3, "count_at_3_again");

        // Software write wins over reload; no match against old value
        wr(OFF_COUNT, 32'd100);
        rd(OFF_COUNT, 32'd100, "write_wins");
        rd(OFF_STATUS, 32'd0, "no_match_on_count_write");
        tick();
        rd(OFF_COUNT, 32'd101, "count_after_write");
        wr(OFF_CTRL, 32'd0);                 // last enabled edge: 102
        tick();
        rd(OFF_COUNT, 32'd102, "count_hold_disabled");

        // Non-reload wrap through 2^32
        wr(OFF_COMPARE, 32'd0);
        wr(OFF_COUNT, 32'hFFFF_FFFE);
        wr(OFF_CTRL, 32'd1);
        rd(OFF_COUNT, 32'hFFFF_FFFE, "wrap_start");
        tick(); rd(OFF_COUNT, 32'hFFFF_FFFF, "wrap_ffffffff");
        tick(); rd(OFF_COUNT, 32'd0, "wrap_zero");
        rd(OFF_STATUS, 32'd0, "wrap_no_match_yet");
        tick();
        rd(OFF_COUNT, 32'd1, "wrap_one");
        rd(OFF_STATUS, 32'd1, "wrap_match");
        chk_irq(1'b0, "irq_masked");

        // Enable IRQ with MATCH pending, then reset mid-count
        wr(OFF_CTRL, 32'd5);
        tick();
        chk_irq(1'b1, "irq_before_reset");
        reset = 1'b1;
        tick();
        chk_irq(1'b0, "rst_irq");
        rd(OFF_CTRL,    32'd0, "rst_ctrl");
        rd(OFF_COUNT,   32'd0, "rst_count");
        rd(OFF_COMPARE, 32'd0, "rst_compare");
        rd(OFF_STATUS,  32'd0, "rst_status");
        rd(OFF_CYCLES,  32'd0, "rst_cycles");
        rd(OFF_RETIRED, 32'd0, "rst_retired");
        bus.MemWriteM = 1'b1;
        bus.DataAdrM  = 32'h0000_0080;
        #1;
        chk("rst_pt_we", {31'd0, bus.DmemWe}, 32'd1);
        bus.MemWriteM = 1'b0;

        // Retired-instruction counting: 7 of 10 cycles non-bubble
        reset     = 1'b0;
        instr_pat = 10'b10_1101_1101;
        for (int i = 0; i < 10; i++) begin
            bus.InstrW = instr_pat[i] ? (32'h0000_0013 + i) : 32'd0;
            tick();
        end
        bus.InstrW = 32'd0;
        rd(OFF_RETIRED, 32'd7,  "retired_7");
        rd(OFF_CYCLES,  32'd10, "cycles_10");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
